// File: rtl/main_memory_arbiter_pkg.sv
// Shared encodings for the main memory arbiter: sequencer states and the
// owner code reported on the status port.
package main_memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        CPU  = 2'b01,
        DBG  = 2'b10
    } owner_e;

endpackage

// File: rtl/main_memory_arbiter_priority_select.sv
// Combinational winner pick between the CPU and debug requesters, using
// round-robin on the previous owner plus the debug burst lock.
module arbiter_priority_select
    import main_memory_arbiter_pkg::*;
(
    input  logic   cpu_req_i,
    input  logic   dbg_req_i,
    input  logic   dbg_lock_i,
    input  owner_e last_owner_i,
    output owner_e winner_o
);

    always_comb begin
        winner_o = NONE;
        case ({cpu_req_i, dbg_req_i})
            2'b10: winner_o = CPU;
            2'b01: winner_o = DBG;
            2'b11: begin
                // A locked debug owner keeps the port; otherwise the other side gets its turn.
                if (last_owner_i == DBG && dbg_lock_i) begin
                    winner_o = DBG;
                end else if (last_owner_i == CPU) begin
                    winner_o = DBG;
                end else begin
                    winner_o = CPU;
                end
            end
            default: winner_o = NONE;
        endcase
    end

endmodule

// File: rtl/main_memory_arbiter.sv
// Shares the single-port main memory between the CPU data port and the debug
// loader port, one access at a time through an IDLE/ACCESS/RESPOND sequencer.
module main_memory_arbiter
    import main_memory_arbiter_pkg::*;
#(
    parameter int ADDRESS_LENGTH = 3,
    parameter int DATA_LENGTH    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [ADDRESS_LENGTH-1:0] cpu_address,
    input  logic [DATA_LENGTH-1:0]    cpu_write_data,
    output logic                      cpu_grant,
    output logic                      cpu_done,
    input  logic                      dbg_req,
    input  logic                      dbg_we,
    input  logic [ADDRESS_LENGTH-1:0] dbg_address,
    input  logic [DATA_LENGTH-1:0]    dbg_write_data,
    input  logic                      dbg_lock,
    output logic                      dbg_grant,
    output logic                      dbg_done,
    output logic [DATA_LENGTH-1:0]    read_data,
    output logic [ADDRESS_LENGTH-1:0] mem_address,
    output logic [DATA_LENGTH-1:0]    mem_write_data,
    output logic                      mem_write_enable,
    input  logic [DATA_LENGTH-1:0]    mem_read_data,
    output logic [1:0]                owner
);

    arb_state_e                state_q, state_d;
    owner_e                    last_owner_q, last_owner_d;
    owner_e                    winner_q, winner_d;
    logic                      cmd_we_q, cmd_we_d;
    logic [ADDRESS_LENGTH-1:0] cmd_address_q, cmd_address_d;
    logic [DATA_LENGTH-1:0]    cmd_write_data_q, cmd_write_data_d;
    logic [DATA_LENGTH-1:0]    read_data_q, read_data_d;
    owner_e                    pick;

    arbiter_priority_select u_priority_select (
        .cpu_req_i    (cpu_req),
        .dbg_req_i    (dbg_req),
        .dbg_lock_i   (dbg_lock),
        .last_owner_i (last_owner_q),
        .winner_o     (pick)
    );

    // Debug starts as last owner so the CPU wins the first tie after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            last_owner_q     <= DBG;
            winner_q         <= NONE;
            cmd_we_q         <= 1'b0;
            cmd_address_q    <= '0;
            cmd_write_data_q <= '0;
            read_data_q      <= '0;
        end else begin
            state_q          <= state_d;
            last_owner_q     <= last_owner_d;
            winner_q         <= winner_d;
            cmd_we_q         <= cmd_we_d;
            cmd_address_q    <= cmd_address_d;
            cmd_write_data_q <= cmd_write_data_d;
            read_data_q      <= read_data_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        last_owner_d     = last_owner_q;
        winner_d         = winner_q;
        cmd_we_d         = cmd_we_q;
        cmd_address_d    = cmd_address_q;
        cmd_write_data_d = cmd_write_data_q;
        read_data_d      = read_data_q;
        case (state_q)
            IDLE: begin
                if (pick != NONE) begin
                    state_d      = ACCESS;
                    winner_d     = pick;
                    last_owner_d = pick;
                    // Requester inputs are captured here and ignored for the rest of the access.
                    if (pick == CPU) begin
                        cmd_we_d         = cpu_we;
                        cmd_address_d    = cpu_address;
                        cmd_write_data_d = cpu_write_data;
                    end else begin
                        cmd_we_d         = dbg_we;
                        cmd_address_d    = dbg_address;
                        cmd_write_data_d = dbg_write_data;
                    end
                end
            end
            ACCESS: begin
                state_d = RESPOND;
                if (!cmd_we_q) begin
                    read_data_d = mem_read_data;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cpu_grant        = 1'b0;
        cpu_done         = 1'b0;
        dbg_grant        = 1'b0;
        dbg_done         = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        owner            = NONE;
        case (state_q)
            ACCESS: begin
                mem_address      = cmd_address_q;
                mem_write_data   = cmd_write_data_q;
                mem_write_enable = cmd_we_q;
                cpu_grant        = (winner_q == CPU);
                dbg_grant        = (winner_q == DBG);
                owner            = winner_q;
            end
            RESPOND: begin
                cpu_done = (winner_q == CPU);
                dbg_done = (winner_q == DBG);
                owner    = winner_q;
            end
            default: ;
        endcase
    end

    assign read_data = read_data_q;

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Bench for main_memory_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_main_memory_arbiter;

    localparam int AW = 3;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_address = '0;
    logic [DW-1:0] cpu_write_data = '0;
    logic          dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
    logic [AW-1:0] dbg_address = '0;
    logic [DW-1:0] dbg_write_data = '0;
    logic          cpu_grant, cpu_done, dbg_grant, dbg_done, mem_write_enable;
    logic [DW-1:0] read_data, mem_write_data, mem_read_data;
    logic [AW-1:0] mem_address;
    logic [1:0]    owner;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    main_memory_arbiter #(.ADDRESS_LENGTH(AW), .DATA_LENGTH(DW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_address(cpu_address),
        .cpu_write_data(cpu_write_data), .cpu_grant(cpu_grant), .cpu_done(cpu_done),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_address(dbg_address),
        .dbg_write_data(dbg_write_data), .dbg_lock(dbg_lock),
        .dbg_grant(dbg_grant), .dbg_done(dbg_done), .read_data(read_data),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data),
        .owner(owner)
    );

    // Main memory: combinational read, write on the clock edge.
    logic [DW-1:0] mem [8] = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333,
                               32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};
    assign mem_read_data = mem[mem_address];
    always @(posedge clk) if (mem_write_enable) mem[mem_address] <= mem_write_data;

    // Model: one outstanding transaction aged 1 (grant cycle) then 2 (done cycle).
    logic [DW-1:0] mMem [8] = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333,
                                32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};
    bit            mValid = 1'b0;
    int            mAge = 0;
    int            mPort = 0;
    int            mLast = 2;
    int            mWin = 0;
    bit            mWe = 1'b0;
    int unsigned   mAddr = 0;
    logic [DW-1:0] mData = '0;
    logic [DW-1:0] mRead = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mValid = 1'b0; mAge = 0; mPort = 0; mLast = 2; mRead = '0;
        end else if (mValid) begin
            if (mAge == 1) begin
                if (mWe) mMem[mAddr] = mData;
                else     mRead = mMem[mAddr];
                mAge = 2;
            end else begin
                mValid = 1'b0;
            end
        end else if (cpu_req || dbg_req) begin
            if (cpu_req && dbg_req) mWin = (mLast == 2 && dbg_lock) ? 2 : 3 - mLast;
            else                    mWin = cpu_req ? 1 : 2;
            mValid = 1'b1; mAge = 1; mPort = mWin; mLast = mWin;
            mWe   = (mWin == 1) ? cpu_we : dbg_we;
            mAddr = (mWin == 1) ? cpu_address : dbg_address;
            mData = (mWin == 1) ? cpu_write_data : dbg_write_data;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        else passes++;
    endtask

    int grantSeq[$];
    int dbgDoneCount = 0;
    bit eAct, eResp;

    always @(posedge clk) begin
        #3;
        eAct  = mValid && mAge == 1;
        eResp = mValid && mAge == 2;
        checkOutput("cpu_grant", cpu_grant, eAct && mPort == 1);
        checkOutput("dbg_grant", dbg_grant, eAct && mPort == 2);
        checkOutput("cpu_done", cpu_done, eResp && mPort == 1);
        checkOutput("dbg_done", dbg_done, eResp && mPort == 2);
        checkOutput("mem_write_enable", mem_write_enable, eAct && mWe);
        checkOutput("owner", owner, mValid ? mPort : 0);
        checkOutput("read_data", read_data, mRead);
        if (eAct || reset) begin
            checkOutput("mem_address", mem_address, eAct ? mAddr : 0);
            checkOutput("mem_write_data", mem_write_data, eAct ? mData : 0);
        end
        if (cpu_grant) grantSeq.push_back(1);
        if (dbg_grant) grantSeq.push_back(2);
        if (dbg_done) dbgDoneCount++;
    end

    task automatic applyStimulus(input bit cReq, input bit cWe, input logic [AW-1:0] cAddr,
                                 input logic [DW-1:0] cData, input bit dReq, input bit dWe,
                                 input logic [AW-1:0] dAddr, input logic [DW-1:0] dData,
                                 input bit lock);
        @(negedge clk);
        cpu_req = cReq; cpu_we = cWe; cpu_address = cAddr; cpu_write_data = cData;
        dbg_req = dReq; dbg_we = dWe; dbg_address = dAddr; dbg_write_data = dData;
        dbg_lock = lock;
    endtask

    task automatic idleInputs();
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0);
    endtask

    task automatic afterEdge();
        @(posedge clk);
        #3;
    endtask

    int exp3[4] = '{1, 2, 1, 2};
    int exp4[5] = '{2, 2, 2, 2, 1};
    int doneSnap;

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        afterEdge();
        checkOutput("rst_owner", owner, 0);
        checkOutput("rst_read_data", read_data, 0);

        // CPU write alone, then debug reads it back.
        applyStimulus(1, 1, 3'd5, 32'hDEADBEEF, 0, 0, '0, '0, 0);
        afterEdge();
        checkOutput("t1_cpu_grant", cpu_grant, 1);
        checkOutput("t1_we_access", mem_write_enable, 1);
        checkOutput("t1_addr", mem_address, 5);
        afterEdge();
        checkOutput("t1_cpu_done", cpu_done, 1);
        checkOutput("t1_we_respond", mem_write_enable, 0);
        checkOutput("t1_mem5", mem[5], 32'hDEADBEEF);
        idleInputs();
        applyStimulus(0, 0, '0, '0, 1, 0, 3'd5, '0, 0);
        afterEdge();
        checkOutput("t1_dbg_grant", dbg_grant, 1);
        afterEdge();
        checkOutput("t1_dbg_done", dbg_done, 1);
        checkOutput("t1_read_back", read_data, 32'hDEADBEEF);
        idleInputs();

        // Tie right after reset: CPU first, debug three cycles later.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        applyStimulus(1, 1, 3'd4, 32'h4444ABCD, 1, 0, 3'd4, '0, 0);
        afterEdge();
        checkOutput("t2_owner_cpu", owner, 1);
        checkOutput("t2_dbg_wait", dbg_grant, 0);
        afterEdge();
        checkOutput("t2_cpu_done", cpu_done, 1);
        applyStimulus(0, 0, '0, '0, 1, 0, 3'd4, '0, 0);
        afterEdge();
        checkOutput("t2_owner_idle", owner, 0);
        afterEdge();
        checkOutput("t2_dbg_grant", dbg_grant, 1);
        checkOutput("t2_owner_dbg", owner, 2);
        afterEdge();
        checkOutput("t2_read", read_data, 32'h4444ABCD);
        idleInputs();

        // Continuous requests without lock alternate owners.
        grantSeq.delete();
        applyStimulus(1, 1, 3'd3, 32'h33330000, 1, 0, 3'd3, '0, 0);
        repeat (11) @(negedge clk);
        idleInputs();
        checkOutput("t3_grant_count", grantSeq.size(), 4);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("t3_grant%0d", i), grantSeq[i], exp3[i]);

        // Debug lock holds the port; releasing it hands the next access to the CPU.
        grantSeq.delete();
        applyStimulus(1, 0, 3'd7, '0, 1, 1, 3'd6, 32'h66660001, 1);
        repeat (11) @(negedge clk);
        applyStimulus(1, 0, 3'd7, '0, 1, 1, 3'd6, 32'h66660001, 0);
        afterEdge();
        checkOutput("t4_cpu_grant", cpu_grant, 1);
        afterEdge();
        checkOutput("t4_cpu_read", read_data, 32'h77777777);
        idleInputs();
        checkOutput("t4_grant_count", grantSeq.size(), 5);
        for (int i = 0; i < 5; i++) checkOutput($sformatf("t4_grant%0d", i), grantSeq[i], exp4[i]);

        // Reset during the ACCESS cycle of a debug write drops it.
        doneSnap = dbgDoneCount;
        applyStimulus(0, 0, '0, '0, 1, 1, 3'd2, 32'hBADC0DE5, 0);
        afterEdge();
        checkOutput("t5_we_before", mem_write_enable, 1);
        @(negedge clk);
        reset = 1'b1;
        dbg_req = 1'b0; dbg_we = 1'b0;
        #1;
        checkOutput("t5_we_reset", mem_write_enable, 0);
        checkOutput("t5_grant_reset", dbg_grant, 0);
        checkOutput("t5_owner_reset", owner, 0);
        checkOutput("t5_read_reset", read_data, 0);
        checkOutput("t5_addr_reset", mem_address, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("t5_no_done", dbgDoneCount, doneSnap);
        checkOutput("t5_mem2", mem[2], 32'h22222222);

        // Address change during ACCESS does not reach memory.
        applyStimulus(1, 0, 3'd1, '0, 0, 0, '0, '0, 0);
        afterEdge();
        checkOutput("t6_addr", mem_address, 1);
        @(negedge clk);
        cpu_address = 3'd6;
        #1;
        checkOutput("t6_addr_held", mem_address, 1);
        afterEdge();
        checkOutput("t6_done", cpu_done, 1);
        checkOutput("t6_read", read_data, 32'h11111111);
        idleInputs();

        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) checkOutput($sformatf("mem%0d", i), mem[i], mMem[i]);
        checkOutput("final_mem3", mem[3], 32'h33330000);
        checkOutput("final_mem6", mem[6], 32'h66660001);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
